// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles the control FSM's decode inputs, the memory handshake and the
// datapath select/enable outputs.
//   master : the control FSM (drives selects, enables, mem_req/mem_we, traps)
//   slave  : datapath + memory side (drives opcode, cmp_true, mem_ack)
// Signals:
//   opcode[6:0]   IR[6:0], valid from DECODE onward
//   cmp_true      branch compare result, valid in BRANCH
//   mem_ack       memory completes the current request this cycle
//   mem_req/mem_we, ir_write, pc_write, pc_src, alu_op[1:0],
//   alu_a_sel[1:0], alu_b_sel[1:0], reg_write, wb_sel[1:0],
//   illegal, bus_err (sticky traps), state[3:0] (debug)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       cmp_true;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic [1:0] alu_op;
  logic [1:0] alu_a_sel;
  logic [1:0] alu_b_sel;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  opcode, cmp_true, mem_ack,
    output mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
           alu_a_sel, alu_b_sel, reg_write, wb_sel, illegal, bus_err, state
  );

  modport slave (
    output opcode, cmp_true, mem_ack,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
           alu_a_sel, alu_b_sel, reg_write, wb_sel, illegal, bus_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle RV32I core. Sequences
// fetch/decode/execute/memory/writeback, drives datapath selects and write
// enables, produces the alu_op code for the ALU-control decoder, and
// handshakes with the unified memory port (req/ack). Illegal opcodes and
// memory timeouts park the FSM in TRAP until reset.
// Parameters:
//   MEM_TIMEOUT  max unacknowledged mem-state cycles (0 = never time out)
//   CNT_W        timeout counter width, MEM_TIMEOUT < 2**CNT_W
// Ports:
//   clk    core clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    multicycle_ctrl_if.master (decode inputs, handshake, selects)
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_if.master     bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ALU operand select codes
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(MEM_TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             jalr_q, jalr_d;

  logic             in_mem;
  logic             timeout_hit;

  logic       mem_req, mem_we, ir_write, pc_write, pc_src, reg_write;
  logic [1:0] alu_op, a_sel, b_sel, wb_sel;

  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);

  // The cycle that would take the count to the limit traps only if it is
  // not acked; an ack in that same cycle completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_mem && !bus.mem_ack &&
                       ((cnt_q + CNT_W'(1)) == TO_LIM);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    jalr_d    = jalr_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        jalr_d = 1'b0;
        case (bus.opcode)
          OP_R:                    state_d = S_EXEC_R;
          OP_IMM, OP_LUI, OP_AUIPC: state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:       state_d = S_ADDR;
          OP_BR:                   state_d = S_BRANCH;
          OP_JAL:                  state_d = S_JUMP;
          OP_JALR: begin
            state_d = S_EXEC_I;
            jalr_d  = 1'b1;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = jalr_q ? S_JUMP : S_WB_ALU;
      S_ADDR:   state_d = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ack) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ack) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change (so on entry to each mem state)
  // and saturates rather than wrapping when no timeout is configured.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_mem && !bus.mem_ack && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    a_sel     = A_PC;
    b_sel     = B_RS2;
    wb_sel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        if (bus.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        // Branch/JAL target computed early into ALU-out.
        a_sel = A_OLDPC;
        b_sel = B_IMM;
      end
      S_EXEC_R: begin
        a_sel  = A_RS1;
        b_sel  = B_RS2;
        alu_op = 2'b10;
      end
      S_EXEC_I: begin
        b_sel = B_IMM;
        if (bus.opcode == OP_IMM) begin
          a_sel  = A_RS1;
          alu_op = 2'b01;
        end else if (bus.opcode == OP_LUI) begin
          a_sel = A_ZERO;
        end else if (bus.opcode == OP_AUIPC) begin
          a_sel = A_OLDPC;
        end else begin
          a_sel = A_RS1;
        end
      end
      S_ADDR: begin
        a_sel = A_RS1;
        b_sel = B_IMM;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        wb_sel    = 2'b00;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      S_BRANCH: begin
        a_sel    = A_RS1;
        b_sel    = B_RS2;
        alu_op   = 2'b11;
        pc_write = bus.cmp_true;
        pc_src   = 1'b1;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        if (jalr_q) begin
          // JALR target rs1+imm goes straight from the ALU to the PC.
          pc_src = 1'b0;
          a_sel  = A_RS1;
          b_sel  = B_IMM;
        end else begin
          pc_src = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      jalr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      jalr_q    <= jalr_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.alu_op    = alu_op;
  assign bus.alu_a_sel = a_sel;
  assign bus.alu_b_sel = b_sel;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Instruction-level reference model: each instruction expands into the list of
// cycles it must take (with expected outputs per cycle) given its opcode,
// branch outcome and memory wait counts. A single apply/compare loop drives
// each cycle's inputs and checks the DUT outputs. Directed sequences come
// first, followed by randomized instruction streams.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic [1:0] a;
    logic [1:0] b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] opc;
    logic       ack;
    logic       cmp;
    logic       chk;
    out_t       e;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  rec_t q[$];
  out_t tr[$];

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111,
                                7'b0010111, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic out_t mk(input logic [3:0] st);
    out_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.st        = bus.state;
    s.mem_req   = bus.mem_req;
    s.mem_we    = bus.mem_we;
    s.ir_write  = bus.ir_write;
    s.pc_write  = bus.pc_write;
    s.pc_src    = bus.pc_src;
    s.alu_op    = bus.alu_op;
    s.a         = bus.alu_a_sel;
    s.b         = bus.alu_b_sel;
    s.reg_write = bus.reg_write;
    s.wb_sel    = bus.wb_sel;
    s.illegal   = bus.illegal;
    s.bus_err   = bus.bus_err;
    return s;
  endfunction

  task automatic push(input out_t e, input logic ack, input logic cmp,
                      input logic [6:0] opc);
    rec_t r;
    r.rst_n = 1'b1; r.opc = opc; r.ack = ack; r.cmp = cmp; r.chk = 1'b1; r.e = e;
    q.push_back(r);
  endtask

  task automatic push_idle();
    push(mk(4'd0), rb(), rb(), 7'($urandom));
  endtask

  task automatic push_reset_unchecked();
    rec_t r;
    r.rst_n = 1'b0; r.opc = '0; r.ack = 1'b0; r.cmp = 1'b0; r.chk = 1'b0; r.e = '0;
    q.push_back(r);
  endtask

  // One memory phase: d unacked cycles then an ack cycle, or a timeout when
  // the request goes TO cycles without an ack.
  task automatic mem_phase(input logic [3:0] st, input int d,
                           input logic [6:0] opc, output bit to);
    out_t e;
    to = 1'b0;
    e = mk(st);
    e.mem_req = 1'b1;
    e.mem_we  = (st == 4'd7);
    if (st == 4'd1) e.b = 2'd2;
    for (int i = 0; i < d && i < TO; i++)
      push(e, 1'b0, rb(), (st == 4'd1) ? 7'($urandom) : opc);
    if (d >= TO) begin
      to = 1'b1;
      return;
    end
    if (st == 4'd1) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end
    push(e, 1'b1, rb(), (st == 4'd1) ? 7'($urandom) : opc);
  endtask

  task automatic push_wb_alu(input logic [6:0] opc);
    out_t e;
    e = mk(4'd8); e.reg_write = 1'b1;
    push(e, rb(), rb(), opc);
  endtask

  task automatic push_jump(input bit is_jalr, input logic [6:0] opc);
    out_t e;
    e = mk(4'd11); e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1;
    if (is_jalr) begin e.a = 2'd2; e.b = 2'd1; end
    else e.pc_src = 1'b1;
    push(e, rb(), rb(), opc);
  endtask

  // kind: 0 completes normally, 1 illegal trap, 2 timeout trap
  task automatic build_instr(input logic [6:0] opc, input logic cmp,
                             input int df, input int dm, output int kind);
    bit   to;
    out_t e;
    kind = 0;
    mem_phase(4'd1, df, opc, to);
    if (to) begin kind = 2; return; end
    e = mk(4'd2); e.a = 2'd1; e.b = 2'd1;
    push(e, rb(), rb(), opc);
    if (opc == 7'b0110011) begin
      e = mk(4'd3); e.a = 2'd2; e.alu_op = 2'd2;
      push(e, rb(), rb(), opc);
      push_wb_alu(opc);
    end else if (opc == 7'b0010011 || opc == 7'b0110111 || opc == 7'b0010111) begin
      e = mk(4'd4); e.b = 2'd1;
      if (opc == 7'b0010011) begin e.a = 2'd2; e.alu_op = 2'd1; end
      else if (opc == 7'b0110111) e.a = 2'd3;
      else e.a = 2'd1;
      push(e, rb(), rb(), opc);
      push_wb_alu(opc);
    end else if (opc == 7'b1100111) begin
      e = mk(4'd4); e.b = 2'd1; e.a = 2'd2;
      push(e, rb(), rb(), opc);
      push_jump(1'b1, opc);
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e = mk(4'd5); e.a = 2'd2; e.b = 2'd1;
      push(e, rb(), rb(), opc);
      mem_phase((opc == 7'b0000011) ? 4'd6 : 4'd7, dm, opc, to);
      if (to) begin kind = 2; return; end
      if (opc == 7'b0000011) begin
        e = mk(4'd9); e.reg_write = 1'b1; e.wb_sel = 2'd1;
        push(e, rb(), rb(), opc);
      end
    end else if (opc == 7'b1100011) begin
      e = mk(4'd10); e.a = 2'd2; e.alu_op = 2'd3; e.pc_src = 1'b1;
      e.pc_write = cmp;
      push(e, rb(), cmp, opc);
    end else if (opc == 7'b1101111) begin
      push_jump(1'b0, opc);
    end else begin
      kind = 1;
    end
  endtask

  // n trap cycles, then a reset cycle still showing TRAP, then IDLE.
  task automatic push_trap(input int kind, input int n);
    out_t e;
    e = mk(4'd15);
    e.illegal = (kind == 1);
    e.bus_err = (kind == 2);
    for (int i = 0; i < n; i++) push(e, rb(), rb(), 7'($urandom));
    push(e, rb(), rb(), 7'($urandom));
    q[q.size()-1].rst_n = 1'b0;
    push_idle();
  endtask

  // Reset asserted during queued cycle k; later cycles never happen.
  task automatic cut_reset(input int k);
    rec_t r;
    while (q.size() > k + 1) void'(q.pop_back());
    r = q[k];
    r.rst_n = 1'b0;
    q[k] = r;
    push_idle();
  endtask

  task automatic run_q();
    rec_t r;
    out_t got;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst_n        = r.rst_n;
      bus.opcode   = r.opc;
      bus.mem_ack  = r.ack;
      bus.cmp_true = r.cmp;
      @(negedge clk);
      cyc++;
      got = sample();
      tr.push_back(got);
      if (r.chk) begin
        n_vec++;
        if (got !== r.e) begin
          n_err++;
          $display("FAIL outputs cyc %0d: got st=%0d bits=%h, required st=%0d bits=%h",
                   cyc, got.st, got, r.e.st, r.e);
        end
      end
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int k, cnt, idx;
    logic [6:0] opc;
    rst_n        = 1'b0;
    bus.opcode   = '0;
    bus.mem_ack  = 1'b0;
    bus.cmp_true = 1'b0;

    // R-type after reset: 0,1,2,3,8,1
    push_reset_unchecked();
    push_idle();
    build_instr(7'b0110011, 1'b0, 0, 0, k);
    build_instr(7'b0110011, 1'b0, 0, 0, k);
    tr.delete();
    run_q();
    lit("reset_state", int'(tr[1].st), 0);
    lit("rtype_seq", int'({tr[1].st, tr[2].st, tr[3].st, tr[4].st, tr[5].st, tr[6].st}),
        24'h012381);
    lit("exec_r_alu_op", int'(tr[4].alu_op), 2);

    // Load with 3 wait cycles in MEM_RD
    build_instr(7'b0000011, 1'b0, 0, 3, k);
    tr.delete();
    run_q();
    idx = -1; cnt = 0;
    foreach (tr[i]) begin
      if (tr[i].st == 4'd9 && idx < 0) idx = i;
      if (tr[i].st == 4'd6 && tr[i].mem_req && !tr[i].mem_we) cnt++;
    end
    lit("load_cycles", idx + 1, 8);
    lit("load_req_held", cnt, 4);
    lit("load_wb_sel", int'(tr[7].wb_sel), 1);

    // Branch taken / not taken, JAL, JALR
    build_instr(7'b1100011, 1'b1, 0, 0, k);
    build_instr(7'b1100011, 1'b0, 0, 0, k);
    build_instr(7'b1101111, 1'b0, 0, 0, k);
    build_instr(7'b1100111, 1'b0, 1, 0, k);
    tr.delete();
    run_q();
    lit("branch_taken_pcw", int'(tr[2].pc_write), 1);
    lit("branch_not_taken_pcw", int'(tr[5].pc_write), 0);

    // Illegal opcode
    build_instr(7'b1111111, 1'b0, 0, 0, k);
    push_trap(k, 20);
    tr.delete();
    run_q();
    lit("illegal_state", int'(tr[2].st), 15);
    lit("illegal_flag", int'(tr[2].illegal), 1);

    // Fetch timeout, then ack exactly on the 4th cycle
    build_instr(7'b0110011, 1'b0, TO, 0, k);
    push_trap(k, 3);
    tr.delete();
    run_q();
    lit("timeout_bus_err", int'(tr[TO].bus_err), 1);
    build_instr(7'b0110011, 1'b0, TO - 1, 0, k);
    tr.delete();
    run_q();
    lit("ack_at_limit_decode", int'(tr[TO].st), 2);

    // Reset during MEM_WR drops the request
    build_instr(7'b0100011, 1'b0, 0, 2, k);
    cut_reset(3);
    tr.delete();
    run_q();
    lit("reset_in_memwr_req", int'(tr[4].mem_req), 0);

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do opc = 7'($urandom); while (is_legal(opc));
      end else begin
        opc = legal_ops[$urandom_range(0, 8)];
      end
      build_instr(opc, rb(),
                  ($urandom_range(0, 24) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3),
                  ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3), k);
      if (k != 0) push_trap(k, $urandom_range(1, 6));
      else if ($urandom_range(0, 24) == 0) cut_reset($urandom_range(0, q.size() - 1));
      run_q();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core, and the producer of the alu_op code consumed by the ALU-control decoder. It sequences fetch/decode/execute/memory/writeback per instruction and drives datapath selects and write enables. It handshakes with the unified memory port via req/ack and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 0, max cycles mem_req may stay unacknowledged; 0 = no timeout
CNT_W, 8, width of the timeout counter; MEM_TIMEOUT < 2**CNT_W

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  IR[6:0], valid from DECODE onward
cmp_true  input  1  branch condition result from ALU/compare logic, valid in BRANCH
mem_ack  input  1  memory completes the current request this cycle
mem_req  output  1  memory request
mem_we  output  1  1 = store, 0 = read
ir_write  output  1  load IR from memory read data
pc_write  output  1  update PC
pc_src  output  1  0 = ALU result (combinational), 1 = ALU-out register
alu_op  output  2  00 ADD, 01 I-type, 10 R-type, 11 branch compare
alu_a_sel  output  2  00 PC, 01 old_pc, 10 rs1, 11 zero
alu_b_sel  output  2  00 rs2, 01 imm, 10 constant 4
reg_write  output  1  register-file write enable
wb_sel  output  2  00 ALU-out reg, 01 memory data reg, 10 PC (already +4)
illegal  output  1  sticky trap: illegal opcode
bus_err  output  1  sticky trap: memory timeout
state  output  4  current state, debug

Behaviour:
- Outputs are decoded combinationally from state (plus mem_ack/cmp_true where stated); any output not listed for a state is 0.
- rst_n low at an edge -> state=IDLE, timeout counter=0, illegal=bus_err=0, regardless of current state (an in-flight mem_req is dropped). While in IDLE all outputs are 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 15.
- IDLE -> FETCH unconditionally.
- FETCH: mem_req=1, a=PC, b=4, alu_op=00. On mem_ack: ir_write=1, pc_write=1, pc_src=0, next DECODE. Otherwise stay.
- DECODE: a=old_pc, b=imm, alu_op=00 (target into ALU-out). Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011, 0110111 (LUI), 0010111 (AUIPC) -> EXEC_I
  - 0000011, 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 (JAL) -> JUMP
  - 1100111 (JALR) -> EXEC_I with JALR flag latched
  - else -> TRAP with illegal=1.
- EXEC_R: a=rs1, b=rs2, alu_op=10 -> WB_ALU.
- EXEC_I: b=imm.
  - OP-IMM: a=rs1, alu_op=01.
  - LUI: a=zero, alu_op=00.
  - AUIPC: a=old_pc, alu_op=00.
  - JALR: a=rs1, alu_op=00; next JUMP.
  - Otherwise next WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00 -> FETCH.
- ADDR: a=rs1, b=imm, alu_op=00 -> MEM_RD if load else MEM_WR.
- MEM_RD: mem_req=1, mem_we=0; on ack -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1; on ack -> FETCH.
- WB_MEM: reg_write=1, wb_sel=01 -> FETCH.
- BRANCH: a=rs1, b=rs2, alu_op=11; pc_write=cmp_true, pc_src=1 -> FETCH.
- JUMP: reg_write=1, wb_sel=10, pc_write=1. pc_src=1 for JAL (DECODE target); pc_src=0 for JALR, with a=rs1, b=imm, alu_op=00 recomputed. Next FETCH.
- TRAP: absorbing until reset; no writes, no mem_req.
- Memory handshake: mem_req/mem_we stable until ack; ack in the first request cycle completes that cycle (zero wait); mem_ack while mem_req=0 is ignored.
- Timeout: counter clears on entering any mem state and increments each unacked mem-state cycle. If MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT with no ack -> TRAP, bus_err=1. Ack on the same cycle the count reaches the limit wins (no error).
- Cycle counts with zero-wait memory:
  - R/I/LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4

Test Plan:
- Reset then R-type opcode 0110011, ack immediate -> states 0,1,2,3,8,1; alu_op=10 in EXEC_R; reg_write=1 only in WB_ALU.
- Load 0000011 with mem_ack delayed 3 cycles in MEM_RD -> mem_req=1/mem_we=0 held 4 cycles; WB_MEM wb_sel=01; total 8 cycles FETCH-to-FETCH.
- Branch 1100011 with cmp_true=1, then again with 0 -> alu_op=11; pc_write=1 pc_src=1 in the first case; pc_write=0 in the second; 3 cycles each.
- JAL and JALR -> JAL: JUMP with pc_src=1, wb_sel=10. JALR: EXEC_I (a=10, alu_op=00) then JUMP with pc_src=0.
- Opcode 1111111 -> TRAP (15), illegal=1; no writes for 20 cycles; rst_n low one edge -> IDLE, illegal=0.
- MEM_TIMEOUT=4, no ack in FETCH -> bus_err=1 after 4 wait cycles. Ack on exactly the 4th cycle -> no error. rst_n low during MEM_WR -> mem_req=0 the next cycle.
